// File: rtl/regbank_wb_arbiter.sv
// Round-robin writeback arbiter for a single register-bank write port, with x0 suppression
// and read-port forwarding. Define REGBANK_WB_ARB_STATS_EN to add stall/drop counters.
module regbank_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REQ    = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data_i,
  output logic                           we_o,
  output logic [ADDR_WIDTH-1:0]          waddr_o,
  output logic [DATA_WIDTH-1:0]          wdata_o,
`ifdef REGBANK_WB_ARB_STATS_EN
  output logic [31:0]                    stall_cnt_o,
  output logic [31:0]                    drop_cnt_o,
`endif
  input  logic [ADDR_WIDTH-1:0]          r0addr_i,
  input  logic [DATA_WIDTH-1:0]          r0data_i,
  output logic [DATA_WIDTH-1:0]          r0data_o,
  input  logic [ADDR_WIDTH-1:0]          r1addr_i,
  input  logic [DATA_WIDTH-1:0]          r1data_i,
  output logic [DATA_WIDTH-1:0]          r1data_o
);

  localparam int              PTR_W    = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]      rr_ptr;
  logic [NUM_REQ-1:0]    grant_p0;
  logic                  found_p0;
  logic                  xfer_p0;
  logic [PTR_W-1:0]      win_idx_p0;
  logic [ADDR_WIDTH-1:0] win_addr_p0;
  logic [DATA_WIDTH-1:0] win_data_p0;

  logic                  we_p1;
  logic [ADDR_WIDTH-1:0] waddr_p1;
  logic [DATA_WIDTH-1:0] wdata_p1;

  function automatic logic [DATA_WIDTH-1:0] forward(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] raw,
    input logic                  wr_en,
    input logic [ADDR_WIDTH-1:0] wr_addr,
    input logic [DATA_WIDTH-1:0] wr_data
  );
    if (addr == '0)
      return '0;
    if (wr_en && (wr_addr == addr))
      return wr_data;
    return raw;
  endfunction

  // Stage p0: the first pass covers rr_ptr..NUM_REQ-1, the second wraps to 0..rr_ptr-1
  always_comb begin
    grant_p0    = '0;
    found_p0    = 1'b0;
    win_idx_p0  = '0;
    win_addr_p0 = '0;
    win_data_p0 = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found_p0 && req_valid_i[k] && (PTR_W'(k) >= rr_ptr)) begin
        found_p0    = 1'b1;
        grant_p0[k] = 1'b1;
        win_idx_p0  = PTR_W'(k);
        win_addr_p0 = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        win_data_p0 = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found_p0 && req_valid_i[k]) begin
        found_p0    = 1'b1;
        grant_p0[k] = 1'b1;
        win_idx_p0  = PTR_W'(k);
        win_addr_p0 = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        win_data_p0 = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Gating with reset keeps grants off while reset is held, before any clock edge
  assign req_ready_o = rst_i ? grant_p0 : '0;
  assign xfer_p0     = found_p0 & rst_i;

  // Stage p1: registered write toward the bank
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rr_ptr   <= '0;
      we_p1    <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else begin
      we_p1 <= 1'b0;
      if (xfer_p0) begin
        rr_ptr   <= (win_idx_p0 == LAST_IDX) ? '0 : win_idx_p0 + 1'b1;
        we_p1    <= |win_addr_p0;
        waddr_p1 <= win_addr_p0;
        wdata_p1 <= win_data_p0;
      end
    end
  end

  assign we_o    = we_p1;
  assign waddr_o = waddr_p1;
  assign wdata_o = wdata_p1;

  assign r0data_o = forward(r0addr_i, r0data_i, we_p1, waddr_p1, wdata_p1);
  assign r1data_o = forward(r1addr_i, r1data_i, we_p1, waddr_p1, wdata_p1);

`ifdef REGBANK_WB_ARB_STATS_EN
  logic stall_p0;
  logic drop_p0;
  logic [31:0] stall_cnt;
  logic [31:0] drop_cnt;

  assign stall_p0 = |(req_valid_i & ~grant_p0);
  assign drop_p0  = xfer_p0 && (win_addr_p0 == '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (stall_p0)
        stall_cnt <= stall_cnt + 32'd1;
      if (drop_p0)
        drop_cnt <= drop_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign drop_cnt_o  = drop_cnt;
`endif

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Randomized bench for regbank_wb_arbiter against a round-robin/forwarding reference model.
// Build with REGBANK_WB_ARB_STATS_EN defined to also check the stall/drop counters.
module tb_regbank_wb_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic [AW-1:0]   r0addr = '0, r1addr = '0;
  logic [DW-1:0]   r0data_in = '0, r1data_in = '0;
  logic [DW-1:0]   r0data_out, r1data_out;
`ifdef REGBANK_WB_ARB_STATS_EN
  logic [31:0] stall_cnt, drop_cnt;
`endif

  regbank_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(N)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_data_i(req_data),
    .we_o(we), .waddr_o(waddr), .wdata_o(wdata),
`ifdef REGBANK_WB_ARB_STATS_EN
    .stall_cnt_o(stall_cnt), .drop_cnt_o(drop_cnt),
`endif
    .r0addr_i(r0addr), .r0data_i(r0data_in), .r0data_o(r0data_out),
    .r1addr_i(r1addr), .r1data_i(r1data_in), .r1data_o(r1data_out)
  );

  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_hold
    assert property (@(posedge clk) disable iff (!rst_i)
      (req_valid[k] && !req_ready[k]) |=>
      (req_valid[k] && $stable(req_addr[k*AW +: AW]) && $stable(req_data[k*DW +: DW])));
  end

  int errors = 0;
  int checks = 0;

  // requester-side state and reference model
  bit            v[N];
  logic [AW-1:0] a[N];
  logic [DW-1:0] d[N];
  int            m_ptr = 0;
  bit            m_we = 0;
  logic [AW-1:0] m_waddr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [31:0]   m_stall = 0, m_drop = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    for (int i = 0; i < N; i++) begin
      int k = (m_ptr + i) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] exp_fwd(input logic [AW-1:0] ad, input logic [DW-1:0] raw);
    if (ad == 0) return '0;
    if (m_we && m_waddr == ad) return m_wdata;
    return raw;
  endfunction

  task automatic apply();
    for (int k = 0; k < N; k++) begin
      req_valid[k]          = v[k];
      req_addr[k*AW +: AW]  = a[k];
      req_data[k*DW +: DW]  = d[k];
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_we = 0; m_waddr = '0; m_wdata = '0; m_stall = 0; m_drop = 0;
  endtask

  task automatic step(output int g);
    logic [N-1:0] er;
    logic [N-1:0] vm;
    apply();
    #1;
    g  = model_grant();
    er = (g >= 0) ? N'(1 << g) : '0;
    for (int k = 0; k < N; k++) vm[k] = v[k];
    check_val("ready", req_ready, er);
    check_val("fwd_r0", r0data_out, exp_fwd(r0addr, r0data_in));
    check_val("fwd_r1", r1data_out, exp_fwd(r1addr, r1data_in));
    if ((vm & ~er) != 0) m_stall++;
    @(posedge clk);
    #1;
    if (g >= 0) begin
      m_ptr   = (g + 1) % N;
      m_we    = (a[g] != 0);
      m_waddr = a[g];
      m_wdata = d[g];
      if (a[g] == 0) m_drop++;
    end else begin
      m_we = 0;
    end
    check_val("we", we, m_we);
    check_val("waddr", waddr, m_waddr);
    check_val("wdata", wdata, m_wdata);
`ifdef REGBANK_WB_ARB_STATS_EN
    check_val("stall_cnt", stall_cnt, m_stall);
    check_val("drop_cnt", drop_cnt, m_drop);
`endif
  endtask

  task automatic new_req(input int k);
    v[k] = bit'($urandom_range(0, 1));
    a[k] = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(1, 31));
    d[k] = $urandom;
  endtask

  initial begin
    int g;
    // reset held with every requester asking
    for (int k = 0; k < N; k++) begin
      v[k] = 1; a[k] = AW'(k + 1); d[k] = $urandom;
    end
    apply();
    r0addr = 5; r0data_in = 32'h5555_0001;
    @(posedge clk);
    #1;
    check_val("rst_ready", req_ready, 0);
    check_val("rst_we", we, 0);
    check_val("rst_waddr", waddr, 0);
    check_val("rst_r0", r0data_out, 32'h5555_0001);
    @(negedge clk);
    rst_i = 1'b1;

    // round-robin fairness, then drain each requester on its grant
    for (int i = 0; i < 6; i++) begin
      step(g);
      check_val("rr_order", g, i % N);
      if (i >= 3 && g >= 0) v[g] = 0;
    end

    // single requester
    v[2] = 1; a[2] = 7; d[2] = 32'hDEAD_BEEF;
    step(g);
    v[2] = 0;
    check_val("single_we", we, 1);
    check_val("single_waddr", waddr, 7);
    check_val("single_wdata", wdata, 32'hDEAD_BEEF);

    // x0 write is accepted but produces no bank write
    v[1] = 1; a[1] = 0; d[1] = 32'h1234;
    r0addr = 0; r0data_in = 32'hFFFF_FFFF;
    step(g);
    v[1] = 0;
    check_val("x0_grant", g, 1);
    check_val("x0_we", we, 0);
    check_val("x0_r0", r0data_out, 0);
`ifdef REGBANK_WB_ARB_STATS_EN
    check_val("x0_drop", drop_cnt, 1);
`endif

    // forwarding of the registered write
    v[0] = 1; a[0] = 9; d[0] = 32'hA5A5_A5A5;
    step(g);
    v[0] = 0;
    r0addr = 9; r1addr = 10; r0data_in = 0; r1data_in = 32'h11;
    #1;
    check_val("fwd_hit_r0", r0data_out, 32'hA5A5_A5A5);
    check_val("fwd_miss_r1", r1data_out, 32'h11);
    step(g);

    // async reset while a write is registered
    for (int k = 0; k < N; k++) begin
      v[k] = 1; a[k] = AW'($urandom_range(1, 31)); d[k] = $urandom;
    end
    step(g);
    check_val("pre_rst_we", we, 1);
    #2 rst_i = 1'b0;
    #1;
    check_val("async_rst_we", we, 0);
    check_val("async_rst_ready", req_ready, 0);
    for (int k = 0; k < N; k++) v[k] = 0;
    apply();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    step(g);
    check_val("no_stale_we", we, 0);

    // randomized traffic
    for (int k = 0; k < N; k++) new_req(k);
    for (int c = 0; c < 400; c++) begin
      r0addr    = ($urandom_range(0, 1) == 1) ? m_waddr : AW'($urandom);
      r1addr    = ($urandom_range(0, 1) == 1) ? m_waddr : AW'($urandom);
      r0data_in = $urandom;
      r1data_in = $urandom;
      step(g);
      if (g >= 0) v[g] = 0;
      for (int k = 0; k < N; k++)
        if (!v[k]) new_req(k);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regbank_wb_arbiter.md
Name: regbank_wb_arbiter

Overview:
- Shares the register bank's single write port between NUM_REQ writeback requesters (e.g. ALU, load unit, CSR unit).
- Uses round-robin grant with a valid/ready handshake per requester.
- Registers the winning write one cycle before it reaches the register bank.
- Suppresses writes to x0 and forwards the in-flight write to both read ports, so readers never see stale data.

Parameters:
- DATA_WIDTH, 32, register data width.
- ADDR_WIDTH, 5, register address width.
- NUM_REQ, 3, number of writeback requesters (2..8).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- req_valid_i  input  NUM_REQ  per-requester write request.
- req_ready_o  output  NUM_REQ  per-requester grant; transfer occurs when valid & ready.
- req_addr_i  input  NUM_REQ*ADDR_WIDTH  flattened destination addresses; requester k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- req_data_i  input  NUM_REQ*DATA_WIDTH  flattened write data, same packing.
- we_o  output  1  register bank write enable.
- waddr_o  output  ADDR_WIDTH  register bank write address.
- wdata_o  output  DATA_WIDTH  register bank write data.
- r0addr_i  input  ADDR_WIDTH  read port 0 address (also driven to the bank).
- r0data_i  input  DATA_WIDTH  raw bank read data, port 0.
- r0data_o  output  DATA_WIDTH  forwarded read data, port 0.
- r1addr_i, r1data_i, r1data_o  same as port 0, for port 1.

Behaviour:
- Reset (rst_i=0, async): we_o=0, waddr_o=0, wdata_o=0, rr_ptr=0, counters=0, req_ready_o=0. Any in-flight write is discarded.
- Arbitration (combinational):
  - Search requesters rr_ptr, rr_ptr+1, … mod NUM_REQ; the first with valid=1 wins.
  - req_ready_o has at most one bit set, only for the winner; all zero if no valid.
  - Ready may depend on valid.
- Requester rule: once valid=1, hold valid, addr and data stable until ready=1. The bench checks this with an assertion.
- Pointer update: on a transfer by requester k, rr_ptr <= (k+1) mod NUM_REQ at the clock edge. With no transfer, rr_ptr holds.
- Output stage, registered, 1-cycle latency:
  - On a transfer by requester k at edge n: waddr_o <= addr_k, wdata_o <= data_k, we_o <= (addr_k != 0).
  - No transfer: we_o <= 0; waddr_o and wdata_o hold their previous values.
  - The register bank captures the write at edge n+1.
  - Throughput: one write per cycle; back-to-back grants allowed.
- x0 suppression: a request to address 0 is accepted (ready=1) and consumes its round-robin turn, but produces we_o=0.
- Forwarding (combinational), per read port p:
  - rpaddr_i==0 -> rpdata_o=0.
  - else we_o=1 and waddr_o==rpaddr_i -> rpdata_o=wdata_o.
  - else rpdata_o=rpdata_i.
- Two requesters targeting the same address on consecutive grants: the later write wins. Forwarding always reflects the currently registered write only.
- Deassertion of rst_i is synchronous to clk_i at system level. No requests are accepted during reset.

Optional Feature:
- Macro: REGBANK_WB_ARB_STATS_EN.
- Defined: adds output stall_cnt_o [31:0] and output drop_cnt_o [31:0].
  - stall_cnt_o increments each cycle in which at least one valid requester is not granted.
  - drop_cnt_o increments on each accepted x0 write.
  - Both counters reset to 0 and wrap at 2^32-1 -> 0.
- Undefined: neither port nor any counter logic exists. All other behaviour is identical.

Test Plan:
- Reset: hold rst_i=0 with all req_valid_i=1 -> req_ready_o=0, we_o=0, waddr_o=0, r0data_o=r0data_i for r0addr_i=5; release -> first grant to requester 0.
- Round-robin fairness: all 3 requesters valid continuously, addrs 1/2/3 -> grants 0,1,2,0,1,2; we_o=1 each cycle from cycle 2 with waddr_o 1,2,3,1…
- Single requester: only requester 2 valid, addr 7, data 0xDEADBEEF -> ready same cycle; next cycle we_o=1, waddr_o=7, wdata_o=0xDEADBEEF; rr_ptr becomes 0.
- x0 write: requester 1 writes addr 0, data 0x1234 -> ready=1, next cycle we_o=0; r0addr_i=0 -> r0data_o=0 (stats build: drop_cnt_o=1).
- Forwarding: registered write addr 9 data 0xA5A5A5A5, r0addr_i=9, r1addr_i=10, r0data_i=0, r1data_i=0x11 -> r0data_o=0xA5A5A5A5, r1data_o=0x11.
- Async reset mid-stream: assert rst_i between edges while we_o=1 -> we_o falls immediately without a clock; after release no stale write is issued.
